// File: rtl/text_term_ctrl_if.sv
// Character-stream and text-RAM write-port bundle for text_term_ctrl.
// The slave side is the controller; the master side is the environment
// (character source plus the RAM, which returns read data).
interface text_term_ctrl_if #(
  parameter int unsigned AW = 12
) ();
  logic          char_valid;
  logic [7:0]    char_data;
  logic          char_ready;
  logic          clr_req;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [7:0]    ram_wdata;
  logic [7:0]    ram_rdata;

  modport master (
    output char_valid, char_data, clr_req, ram_rdata,
    input  char_ready, ram_addr, ram_we, ram_wdata
  );

  modport slave (
    input  char_valid, char_data, clr_req, ram_rdata,
    output char_ready, ram_addr, ram_we, ram_wdata
  );
endinterface

// File: rtl/text_term_ctrl.sv
// Terminal-style controller owning the write port of the text RAM.
// Writes printable bytes at the cursor, interprets CR/LF/BS/FF, scrolls by
// copying rows up one at a time, and clears the screen on request or reset.
module text_term_ctrl #(
  parameter int unsigned COLS = 80,
  parameter int unsigned ROWS = 40,
  parameter int unsigned AW   = 12,
  parameter logic [7:0]  FILL = 8'h20
) (
  input  logic                clk25MHz,
  input  logic                reset,
  text_term_ctrl_if.slave     term,
  output logic [7:0]          cur_x,
  output logic [7:0]          cur_y,
  output logic                busy
);

  localparam logic [2:0] StIdle       = 3'd0;
  localparam logic [2:0] StWrite      = 3'd1;
  localparam logic [2:0] StScrollRd   = 3'd2;
  localparam logic [2:0] StScrollWr   = 3'd3;
  localparam logic [2:0] StScrollFill = 3'd4;
  localparam logic [2:0] StClear      = 3'd5;

  localparam logic [AW-1:0] ColsA     = AW'(COLS);
  localparam logic [AW-1:0] LastCell  = AW'(COLS * ROWS - 1);
  localparam logic [AW-1:0] LastCopy  = AW'(COLS * (ROWS - 1) - 1);
  localparam logic [AW-1:0] FillStart = AW'(COLS * (ROWS - 1));
  localparam logic [AW-1:0] OneA      = AW'(1);
  localparam logic [7:0]    LastCol   = 8'(COLS - 1);
  localparam logic [7:0]    LastRow   = 8'(ROWS - 1);

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] index_q, index_d;
  logic [7:0]    cur_x_q, cur_x_d;
  logic [7:0]    cur_y_q, cur_y_d;
  logic [7:0]    byte_q, byte_d;
  logic          clr_pend_q, clr_pend_d;
  logic [AW-1:0] wr_addr;
  logic          printable;

  assign wr_addr   = AW'(cur_y_q) * ColsA + AW'(cur_x_q);
  assign printable = (term.char_data >= 8'h20) && (term.char_data != 8'h7F);

  // Next-state, cursor and copy-index update.
  always_comb begin
    state_d    = state_q;
    index_d    = index_q;
    cur_x_d    = cur_x_q;
    cur_y_d    = cur_y_q;
    byte_d     = byte_q;
    clr_pend_d = clr_pend_q | term.clr_req;
    case (state_q)
      StIdle: begin
        // A pending or fresh clear wins over any offered character.
        if (clr_pend_q || term.clr_req) begin
          state_d    = StClear;
          index_d    = '0;
          clr_pend_d = 1'b0;
        end else if (term.char_valid) begin
          if (printable) begin
            byte_d  = term.char_data;
            state_d = StWrite;
          end else begin
            case (term.char_data)
              8'h0D: cur_x_d = '0;
              8'h0A: begin
                if (cur_y_q < LastRow) begin
                  cur_y_d = cur_y_q + 8'd1;
                end else begin
                  state_d = StScrollRd;
                  index_d = '0;
                end
              end
              8'h08: begin
                if (cur_x_q != 8'd0) cur_x_d = cur_x_q - 8'd1;
              end
              8'h0C: begin
                state_d = StClear;
                index_d = '0;
              end
              default: ;
            endcase
          end
        end
      end
      StWrite: begin
        if (cur_x_q < LastCol) begin
          cur_x_d = cur_x_q + 8'd1;
          state_d = StIdle;
        end else if (cur_y_q < LastRow) begin
          cur_x_d = '0;
          cur_y_d = cur_y_q + 8'd1;
          state_d = StIdle;
        end else begin
          cur_x_d = '0;
          state_d = StScrollRd;
          index_d = '0;
        end
      end
      StScrollRd: state_d = StScrollWr;
      StScrollWr: begin
        if (index_q == LastCopy) begin
          index_d = FillStart;
          state_d = StScrollFill;
        end else begin
          index_d = index_q + OneA;
          state_d = StScrollRd;
        end
      end
      StScrollFill: begin
        if (index_q == LastCell) state_d = StIdle;
        else                     index_d = index_q + OneA;
      end
      StClear: begin
        if (index_q == LastCell) begin
          state_d = StIdle;
          cur_x_d = '0;
          cur_y_d = '0;
        end else begin
          index_d = index_q + OneA;
        end
      end
      default: begin
        state_d = StClear;
        index_d = '0;
      end
    endcase
  end

  // State registers; reset restarts a full-screen clear.
  always_ff @(posedge clk25MHz) begin
    if (reset) begin
      state_q    <= StClear;
      index_q    <= '0;
      cur_x_q    <= '0;
      cur_y_q    <= '0;
      byte_q     <= '0;
      clr_pend_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      index_q    <= index_d;
      cur_x_q    <= cur_x_d;
      cur_y_q    <= cur_y_d;
      byte_q     <= byte_d;
      clr_pend_q <= clr_pend_d;
    end
  end

  // RAM port drive; held quiet while reset is asserted.
  always_comb begin
    term.ram_we    = 1'b0;
    term.ram_addr  = '0;
    term.ram_wdata = FILL;
    if (!reset) begin
      case (state_q)
        StWrite: begin
          term.ram_we    = 1'b1;
          term.ram_addr  = wr_addr;
          term.ram_wdata = byte_q;
        end
        // Source address is presented here; sync RAM returns it next cycle.
        StScrollRd: term.ram_addr = index_q + ColsA;
        StScrollWr: begin
          term.ram_we    = 1'b1;
          term.ram_addr  = index_q;
          term.ram_wdata = term.ram_rdata;
        end
        StScrollFill, StClear: begin
          term.ram_we   = 1'b1;
          term.ram_addr = index_q;
        end
        default: ;
      endcase
    end
  end

  // Handshake and status outputs.
  always_comb begin
    term.char_ready = !reset && (state_q == StIdle) && !clr_pend_q && !term.clr_req;
    busy            = reset || (state_q != StIdle);
    cur_x           = cur_x_q;
    cur_y           = cur_y_q;
  end

endmodule

// File: tb/tb_text_term_ctrl.sv
// Self-checking bench for text_term_ctrl: directed steps plus random character
// traffic, checked against a screen-array model of the terminal.
module tb_text_term_ctrl;
  localparam int AW    = 12;
  localparam int COLS  = 80;
  localparam int ROWS  = 40;
  localparam int CELLS = COLS * ROWS;
  localparam int LIMIT = 20000;

  logic clk = 1'b0;
  logic reset;
  logic [7:0] cur_x, cur_y;
  logic busy;

  logic          tb_we = 1'b0;
  logic [AW-1:0] tb_addr = '0;
  logic [7:0]    tb_data = '0;
  logic [7:0]    mem [0:4095];

  int tests = 0;
  int fails = 0;

  // Reference model: screen contents and cursor.
  logic [7:0] scr [0:CELLS-1];
  int mx, my;

  text_term_ctrl_if #(.AW(AW)) tif ();

  text_term_ctrl #(.COLS(COLS), .ROWS(ROWS), .AW(AW), .FILL(8'h20)) dut (
    .clk25MHz (clk),
    .reset    (reset),
    .term     (tif),
    .cur_x    (cur_x),
    .cur_y    (cur_y),
    .busy     (busy)
  );

  always #20 clk = ~clk;

  // Synchronous text RAM with a bench-side preload port.
  always @(posedge clk) begin
    if (tb_we) mem[tb_addr] <= tb_data;
    else if (tif.ram_we) mem[tif.ram_addr] <= tif.ram_wdata;
    tif.ram_rdata <= mem[tif.ram_addr];
  end

  task automatic check(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < CELLS; i++) scr[i] = 8'h20;
    mx = 0;
    my = 0;
  endtask

  task automatic model_scroll();
    for (int i = 0; i < CELLS - COLS; i++) scr[i] = scr[i + COLS];
    for (int i = CELLS - COLS; i < CELLS; i++) scr[i] = 8'h20;
  endtask

  task automatic model_char(input logic [7:0] c);
    if (c >= 8'h20 && c != 8'h7F) begin
      scr[my * COLS + mx] = c;
      if (mx < COLS - 1) mx++;
      else begin
        mx = 0;
        if (my < ROWS - 1) my++;
        else model_scroll();
      end
    end else begin
      case (c)
        8'h0D: mx = 0;
        8'h0A: if (my < ROWS - 1) my++; else model_scroll();
        8'h08: if (mx > 0) mx--;
        8'h0C: model_clear();
        default: ;
      endcase
    end
  endtask

  task automatic check_screen(input string tag);
    int diffs = 0;
    for (int i = 0; i < CELLS; i++) if (mem[i] !== scr[i]) diffs++;
    check(tag, diffs, 0);
  endtask

  task automatic check_cursor(input string tag, input int x, input int y);
    check({tag, "_x"}, int'(cur_x), x);
    check({tag, "_y"}, int'(cur_y), y);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(negedge clk);
    while (busy && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", int'(n < LIMIT), 1);
  endtask

  // Offer one byte, wait for the transfer, and check the resulting write.
  task automatic send_char(input logic [7:0] c);
    int n = 0;
    int exp_addr;
    bit printable;
    printable = (c >= 8'h20 && c != 8'h7F);
    exp_addr = my * COLS + mx;
    @(negedge clk);
    tif.char_valid = 1'b1;
    tif.char_data  = c;
    while (!tif.char_ready && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("ready_timeout", int'(n < LIMIT), 1);
    @(posedge clk);
    #1 tif.char_valid = 1'b0;
    model_char(c);
    if (printable) begin
      @(negedge clk);
      check("wr_we", int'(tif.ram_we), 1);
      check("wr_addr", int'(tif.ram_addr), exp_addr);
      check("wr_data", int'(tif.ram_wdata), int'(c));
    end
  endtask

  function automatic logic [7:0] rand_char();
    int r = $urandom_range(0, 99);
    if (r < 62) return 8'($urandom_range(32, 126));
    if (r < 68) return 8'($urandom_range(128, 255));
    if (r < 80) return 8'h0A;
    if (r < 86) return 8'h0D;
    if (r < 92) return 8'h08;
    if (r < 93) return 8'h0C;
    if (r < 96) return 8'h7F;
    return 8'($urandom_range(0, 31));
  endfunction

  initial begin
    int bad;
    int n;
    reset          = 1'b1;
    tif.char_valid = 1'b0;
    tif.char_data  = '0;
    tif.clr_req    = 1'b0;
    mx = 0;
    my = 0;

    // Step 1: garbage preload under reset, then the power-up clear stream.
    bad = 0;
    for (int i = 0; i < CELLS; i++) begin
      @(negedge clk);
      tb_we   = 1'b1;
      tb_addr = AW'(i);
      tb_data = 8'($urandom);
      if (tif.ram_we !== 1'b0) bad++;
    end
    @(negedge clk);
    tb_we = 1'b0;
    check("reset_we_low", bad, 0);
    check("reset_busy", int'(busy), 1);
    check("reset_ready", int'(tif.char_ready), 0);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < CELLS; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      if (tif.ram_we !== 1'b1 || int'(tif.ram_addr) != i || tif.ram_wdata !== 8'h20) bad++;
    end
    check("clear_stream", bad, 0);
    @(negedge clk);
    check("post_clear_we", int'(tif.ram_we), 0);
    check("post_clear_ready", int'(tif.char_ready), 1);
    check("post_clear_busy", int'(busy), 0);
    check_cursor("post_clear", 0, 0);
    model_clear();
    check_screen("screen_after_clear");

    // Step 2: two printable characters from home.
    send_char(8'h41);
    send_char(8'h42);
    wait_idle();
    check_cursor("ab", 2, 0);
    check("mem0", int'(mem[0]), 'h41);
    check("mem1", int'(mem[1]), 'h42);

    // Step 3: line wrap at column 79, then CR, BS and LF at column 0.
    for (int i = 0; i < 5; i++) send_char(8'h0A);
    send_char(8'h0D);
    for (int i = 0; i < COLS - 1; i++) send_char(8'($urandom_range(33, 126)));
    wait_idle();
    check_cursor("at_79_5", 79, 5);
    send_char(8'h5A);
    wait_idle();
    check("mem479", int'(mem[479]), 'h5A);
    check_cursor("wrap", 0, 6);
    send_char(8'h0D);
    wait_idle();
    check_cursor("cr", 0, 6);
    send_char(8'h08);
    wait_idle();
    check_cursor("bs", 0, 6);
    send_char(8'h0A);
    wait_idle();
    check_cursor("lf", 0, 7);

    // Random traffic against the model.
    for (int i = 0; i < 300; i++) send_char(rand_char());
    wait_idle();
    check_cursor("random", mx, my);
    check_screen("screen_random");

    // Step 4: LF on the bottom row scrolls a preloaded screen.
    send_char(8'h0C);
    wait_idle();
    for (int i = 0; i < ROWS - 1; i++) send_char(8'h0A);
    for (int i = 0; i < 3; i++) send_char(8'h71);
    wait_idle();
    check_cursor("pre_scroll", 3, 39);
    for (int i = 0; i < CELLS; i++) begin
      @(negedge clk);
      tb_we   = 1'b1;
      tb_addr = AW'(i);
      tb_data = 8'(i / COLS + 1);
      scr[i]  = 8'(i / COLS + 1);
    end
    @(negedge clk);
    tb_we = 1'b0;
    send_char(8'h0A);
    n = 0;
    @(negedge clk);
    while (busy && n < LIMIT) begin
      n++;
      @(negedge clk);
    end
    check("scroll_cycles", n, 2 * COLS * (ROWS - 1) + COLS);
    check("scroll_ready", int'(tif.char_ready), 1);
    check_cursor("scroll", 3, 39);
    check("row0", int'(mem[0]), 2);
    check("row38", int'(mem[38 * COLS + 17]), 40);
    check("row39", int'(mem[39 * COLS + 5]), 'h20);
    check_screen("screen_scroll");

    // Step 5: clear request during a scroll, with 'A' held on the stream.
    @(negedge clk);
    tif.char_valid = 1'b1;
    tif.char_data  = 8'h0A;
    n = 0;
    while (!tif.char_ready && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("lf_ready", int'(tif.char_ready), 1);
    @(posedge clk);
    #1 tif.char_data = 8'h41;
    model_char(8'h0A);
    n = 0;
    repeat (100) begin
      @(negedge clk);
      n++;
    end
    tif.clr_req = 1'b1;
    @(negedge clk);
    n++;
    tif.clr_req = 1'b0;
    while (!tif.char_ready && n < LIMIT) begin
      @(negedge clk);
      n++;
    end
    check("scroll_then_clear_cycles", n, 2 * COLS * (ROWS - 1) + COLS + 1 + CELLS + 1);
    model_clear();
    check_cursor("after_pend_clear", 0, 0);
    check_screen("screen_pend_clear");
    @(posedge clk);
    #1 tif.char_valid = 1'b0;
    model_char(8'h41);
    @(negedge clk);
    check("held_we", int'(tif.ram_we), 1);
    check("held_addr", int'(tif.ram_addr), 0);
    check("held_data", int'(tif.ram_wdata), 'h41);
    wait_idle();
    check_cursor("held", 1, 0);

    // Step 6: reset pulse in the middle of a clear restarts it.
    send_char(8'h78);
    send_char(8'h79);
    wait_idle();
    check_cursor("pre_reset", 3, 0);
    tif.clr_req = 1'b1;
    @(negedge clk);
    tif.clr_req = 1'b0;
    repeat (1000) @(negedge clk);
    check("mid_clear_busy", int'(busy), 1);
    reset = 1'b1;
    #1;
    check("mid_reset_we", int'(tif.ram_we), 0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("restart_we", int'(tif.ram_we), 1);
    check("restart_addr", int'(tif.ram_addr), 0);
    check("restart_data", int'(tif.ram_wdata), 'h20);
    check_cursor("restart", 0, 0);
    n = 1;
    @(negedge clk);
    while (busy && n < LIMIT) begin
      if (tif.ram_we) n++;
      @(negedge clk);
    end
    check("restart_clear_len", n, CELLS);
    model_clear();
    check_screen("screen_restart");
    check("final_ready", int'(tif.char_ready), 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
